video_command_sequencer: RTL and testbench
==========================================

VIDEO_COMMAND_SEQUENCER -- requirements
Module: video_command_sequencer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, command queue depth (power of two, 2..16).
REQ-002 SHALL have parameter BUSY_TIMEOUT, default 7, max cycles waited for vc_busy to rise after a strobe (1..15).
REQ-003 clk_100mhz  input  1  sole clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous active-low reset (LOW at a rising edge = reset).
REQ-005 cmd_valid  input  1  requester presents a command.
REQ-006 cmd_ready  output  1  queue can accept; HIGH iff queue not full.
REQ-007 cmd_op  input  3  0 draw, 1 clear, 2 scroll left, 3 scroll right, 4 scroll down, 5-7 illegal.
REQ-008 cmd_sprite  input  16; cmd_row input 6; cmd_col input 7; cmd_amount input 4: operands stored with the command.
REQ-009 draw_sprite, clear_screen, scroll_left, scroll_right, scroll_down  output  1 each  registered one-cycle strobes to video controller.
REQ-010 sprite 16, draw_row 6, draw_col 7, scroll_down_amount 4  output  registered operands of the command in flight.
REQ-011 vc_busy  input  1  video controller busy; vc_colision  input  1  collision result of last draw.
REQ-012 done  output  1  one-cycle pulse per retired command; done_collision output 1, done_error output 1, both valid only with done.
REQ-013 idle  output  1  HIGH iff queue empty and FSM in IDLE; fifo_count  output  5  queued entries.

Function
REQ-014 Command SHALL be enqueued at an edge where cmd_valid && cmd_ready; cmd_ready SHALL not depend on a same-cycle pop (full queue rejects even if popping).
REQ-015 Queue SHALL be FIFO order; write/read pointers wrap modulo FIFO_DEPTH; fifo_count = 0..FIFO_DEPTH.
REQ-016 FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RETIRE.
REQ-017 IDLE -> ISSUE when queue non-empty and vc_busy LOW; head entry popped and operands registered onto outputs on that edge.
REQ-018 Illegal op at head: IDLE -> RETIRE directly, no strobe, done_error=1, done_collision=0.
REQ-019 ISSUE: exactly one strobe matching op HIGH for exactly one cycle; all strobes otherwise LOW; at most one strobe HIGH ever. ISSUE -> WAIT_BUSY unconditionally.
REQ-020 Operand outputs SHALL hold stable from ISSUE until next ISSUE.
REQ-021 WAIT_BUSY: vc_busy HIGH -> WAIT_DONE; else count cycles; after BUSY_TIMEOUT cycles LOW -> RETIRE with done_error=1.
REQ-022 WAIT_DONE: vc_busy LOW -> RETIRE; done_collision latched from vc_colision on that edge if op was draw, else 0; done_error=0.
REQ-023 RETIRE: done HIGH one cycle; -> IDLE. Minimum issue-to-issue spacing therefore 4 cycles plus controller busy time.
REQ-024 Enqueue during any state SHALL proceed independently of the FSM; enqueue and pop on same edge leave fifo_count unchanged.
REQ-025 Non-draw ops SHALL not alter done_collision from 0; scroll_down_amount driven only from cmd_amount (other ops: don't-care but stable).
REQ-026 RTL SHALL be synthesizable, no latches, no combinational path from inputs to strobes.

Reset
REQ-027 On rst LOW: FSM IDLE, queue emptied (pointers 0, fifo_count 0), all strobes 0, operand outputs 0, done/done_collision/done_error 0, cmd_ready 1, idle 1.
REQ-028 Reset mid-command SHALL abandon the command without done pulse; commands presented while rst LOW SHALL not be enqueued.

Verification
REQ-029 Draw op, row 5, col 10, sprite 16'hF0F0, vc_busy rises 1 cycle after strobe, falls 20 later with vc_colision=1 -> one draw_sprite pulse, draw_row=5, draw_col=10, done with done_collision=1.
REQ-030 Push 5 commands back-to-back with vc_busy held HIGH, FIFO_DEPTH=4 -> 4 accepted, cmd_ready LOW on 5th, fifo_count=4, no strobe until vc_busy LOW.
REQ-031 Sequence clear, scroll left, scroll down amount 3 -> strobes in that order, one each, scroll_down_amount=3 at third ISSUE, three done pulses, done_collision=0.
REQ-032 Op=6 queued -> no strobe, done with done_error=1 within 2 cycles of pop; following legal command issues normally.
REQ-033 Draw issued, vc_busy never rises -> done_error=1 after BUSY_TIMEOUT=7 cycles in WAIT_BUSY.
REQ-034 rst LOW during WAIT_DONE with 2 queued -> next cycle idle=1, fifo_count=0, no done, no strobe.

Source files
------------

// File: rtl/video_command_sequencer_if.sv
// Command request channel between a requester and the video command sequencer.
interface video_command_sequencer_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [2:0]  cmd_op;
   logic [15:0] cmd_sprite;
   logic [5:0]  cmd_row;
   logic [6:0]  cmd_col;
   logic [3:0]  cmd_amount;

   modport master (
      output cmd_valid, cmd_op, cmd_sprite, cmd_row, cmd_col, cmd_amount,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_sprite, cmd_row, cmd_col, cmd_amount,
      output cmd_ready
   );
endinterface

// File: rtl/video_command_sequencer.sv
// Video command sequencer: queues draw/clear/scroll commands and issues them one at a
// time to the video controller, following its busy handshake before retiring each one.
module video_command_sequencer #(
   parameter int unsigned FIFO_DEPTH   = 4,
   parameter int unsigned BUSY_TIMEOUT = 7
) (
   input  logic                     clk_100mhz,
   input  logic                     rst,
   video_command_sequencer_if.slave cmd,
   output logic                     draw_sprite,
   output logic                     clear_screen,
   output logic                     scroll_left,
   output logic                     scroll_right,
   output logic                     scroll_down,
   output logic [15:0]              sprite,
   output logic [5:0]               draw_row,
   output logic [6:0]               draw_col,
   output logic [3:0]               scroll_down_amount,
   input  logic                     vc_busy,
   input  logic                     vc_colision,
   output logic                     done,
   output logic                     done_collision,
   output logic                     done_error,
   output logic                     idle,
   output logic [4:0]               fifo_count
);
   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   localparam logic [2:0] OP_DRAW         = 3'd0;
   localparam logic [2:0] OP_CLEAR        = 3'd1;
   localparam logic [2:0] OP_SCROLL_LEFT  = 3'd2;
   localparam logic [2:0] OP_SCROLL_RIGHT = 3'd3;
   localparam logic [2:0] OP_SCROLL_DOWN  = 3'd4;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_ISSUE     = 3'd1;
   localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
   localparam logic [2:0] ST_WAIT_DONE = 3'd3;
   localparam logic [2:0] ST_RETIRE    = 3'd4;

   localparam logic [3:0] TIMEOUT_LAST = 4'(BUSY_TIMEOUT - 1);
   localparam logic [4:0] COUNT_FULL   = 5'(FIFO_DEPTH);

   logic [2:0]       op_mem     [FIFO_DEPTH];
   logic [15:0]      sprite_mem [FIFO_DEPTH];
   logic [5:0]       row_mem    [FIFO_DEPTH];
   logic [6:0]       col_mem    [FIFO_DEPTH];
   logic [3:0]       amount_mem [FIFO_DEPTH];

   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [4:0]       count_q;
   logic [2:0]       state_q, state_d;
   logic [3:0]       timer_q, timer_d;
   logic [2:0]       cur_op_q;
   logic [4:0]       strobe_q, strobe_d;
   logic [15:0]      sprite_q;
   logic [5:0]       row_q;
   logic [6:0]       col_q;
   logic [3:0]       amount_q;
   logic             done_q, done_d;
   logic             coll_q, coll_d;
   logic             err_q, err_d;

   logic             push, pop, head_legal;
   logic [2:0]       head_op;

   // Ready comes from the registered count only, so a full queue rejects even while popping
   assign cmd.cmd_ready = (count_q != COUNT_FULL);
   assign push          = cmd.cmd_valid && cmd.cmd_ready;
   assign head_op       = op_mem[rd_ptr_q];
   assign head_legal    = (head_op <= OP_SCROLL_DOWN);
   assign pop           = (state_q == ST_IDLE) && (count_q != 5'd0) && !vc_busy;

   assign draw_sprite        = strobe_q[0];
   assign clear_screen       = strobe_q[1];
   assign scroll_left        = strobe_q[2];
   assign scroll_right       = strobe_q[3];
   assign scroll_down        = strobe_q[4];
   assign sprite             = sprite_q;
   assign draw_row           = row_q;
   assign draw_col           = col_q;
   assign scroll_down_amount = amount_q;
   assign done               = done_q;
   assign done_collision     = coll_q;
   assign done_error         = err_q;
   assign fifo_count         = count_q;
   assign idle               = (count_q == 5'd0) && (state_q == ST_IDLE);

   // One-hot strobe for the head op, loaded on a legal pop so it is high only during ISSUE
   always_comb begin
      strobe_d = 5'b00000;
      if (pop && head_legal) begin
         case (head_op)
            OP_DRAW:         strobe_d = 5'b00001;
            OP_CLEAR:        strobe_d = 5'b00010;
            OP_SCROLL_LEFT:  strobe_d = 5'b00100;
            OP_SCROLL_RIGHT: strobe_d = 5'b01000;
            OP_SCROLL_DOWN:  strobe_d = 5'b10000;
            default:         strobe_d = 5'b00000;
         endcase
      end
   end

   // Command FSM next state, busy-wait timer and retire status
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      done_d  = 1'b0;
      coll_d  = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (pop) begin
               if (head_legal) begin
                  state_d = ST_ISSUE;
               end else begin
                  // Illegal op retires straight away without touching the controller
                  state_d = ST_RETIRE;
                  done_d  = 1'b1;
                  err_d   = 1'b1;
               end
            end
         end
         ST_ISSUE: begin
            state_d = ST_WAIT_BUSY;
            timer_d = 4'd0;
         end
         ST_WAIT_BUSY: begin
            if (vc_busy) begin
               state_d = ST_WAIT_DONE;
            end else if (timer_q == TIMEOUT_LAST) begin
               state_d = ST_RETIRE;
               done_d  = 1'b1;
               err_d   = 1'b1;
            end else begin
               timer_d = timer_q + 4'd1;
            end
         end
         ST_WAIT_DONE: begin
            if (!vc_busy) begin
               state_d = ST_RETIRE;
               done_d  = 1'b1;
               coll_d  = (cur_op_q == OP_DRAW) && vc_colision;
            end
         end
         ST_RETIRE: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Queue storage; validity is tracked by pointers and count, so contents need no reset
   always_ff @(posedge clk_100mhz) begin
      if (rst && push) begin
         op_mem[wr_ptr_q]     <= cmd.cmd_op;
         sprite_mem[wr_ptr_q] <= cmd.cmd_sprite;
         row_mem[wr_ptr_q]    <= cmd.cmd_row;
         col_mem[wr_ptr_q]    <= cmd.cmd_col;
         amount_mem[wr_ptr_q] <= cmd.cmd_amount;
      end
   end

   // Queue pointers and occupancy; push and pop are independent of each other
   always_ff @(posedge clk_100mhz) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= 5'd0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_q <= count_q + 5'd1;
            2'b01:   count_q <= count_q - 5'd1;
            default: count_q <= count_q;
         endcase
      end
   end

   // FSM state, strobes, status pulses and operands of the command in flight
   always_ff @(posedge clk_100mhz) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         timer_q  <= 4'd0;
         cur_op_q <= OP_DRAW;
         strobe_q <= 5'b00000;
         sprite_q <= 16'd0;
         row_q    <= 6'd0;
         col_q    <= 7'd0;
         amount_q <= 4'd0;
         done_q   <= 1'b0;
         coll_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         strobe_q <= strobe_d;
         done_q   <= done_d;
         coll_q   <= coll_d;
         err_q    <= err_d;
         // Operands change only when a legal command issues, so they hold between issues
         if (pop && head_legal) begin
            cur_op_q <= head_op;
            sprite_q <= sprite_mem[rd_ptr_q];
            row_q    <= row_mem[rd_ptr_q];
            col_q    <= col_mem[rd_ptr_q];
            amount_q <= amount_mem[rd_ptr_q];
         end
      end
   end
endmodule

// File: tb/tb_video_command_sequencer.sv
// Self-checking bench for video_command_sequencer: directed scenarios plus a randomized
// run scored against a command-level reference model and a reactive controller model.
module tb_video_command_sequencer;
   localparam int DEPTH = 4;
   localparam int TMO   = 7;

   typedef struct packed {
      logic [2:0]  op;
      logic [15:0] sprite;
      logic [5:0]  row;
      logic [6:0]  col;
      logic [3:0]  amt;
   } cmd_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        draw_sprite, clear_screen, scroll_left, scroll_right, scroll_down;
   logic [15:0] sprite;
   logic [5:0]  draw_row;
   logic [6:0]  draw_col;
   logic [3:0]  scroll_down_amount;
   logic        vc_busy, vc_colision;
   logic        done, done_collision, done_error, idle;
   logic [4:0]  fifo_count;

   logic        man_busy, man_col;
   logic        ctl_busy, ctl_col, ctl_active;
   logic        ctl_on, ctl_rand, ctl_never, ctl_c;
   int          ctl_delay, ctl_len;

   int          vectors = 0;
   int          miscompares = 0;
   int          cyc = 0;
   int          multi_cnt = 0;
   int          stray_cnt = 0;

   cmd_t        st_q[$];
   int          st_cyc_q[$];
   logic [1:0]  dn_q[$];
   int          dn_cyc_q[$];
   logic [1:0]  ctl_q[$];

   video_command_sequencer_if cif ();

   assign vc_busy     = ctl_busy | man_busy;
   assign vc_colision = ctl_on ? ctl_col : man_col;

   video_command_sequencer #(
      .FIFO_DEPTH  (DEPTH),
      .BUSY_TIMEOUT(TMO)
   ) dut (
      .clk_100mhz        (clk),
      .rst               (rst),
      .cmd               (cif),
      .draw_sprite       (draw_sprite),
      .clear_screen      (clear_screen),
      .scroll_left       (scroll_left),
      .scroll_right      (scroll_right),
      .scroll_down       (scroll_down),
      .sprite            (sprite),
      .draw_row          (draw_row),
      .draw_col          (draw_col),
      .scroll_down_amount(scroll_down_amount),
      .vc_busy           (vc_busy),
      .vc_colision       (vc_colision),
      .done              (done),
      .done_collision    (done_collision),
      .done_error        (done_error),
      .idle              (idle),
      .fifo_count        (fifo_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Log every strobe and retire seen on the outputs
   always @(negedge clk) begin
      cmd_t rec;
      int   n;
      n = $countones({scroll_down, scroll_right, scroll_left, clear_screen, draw_sprite});
      if (n > 1) multi_cnt++;
      if (n >= 1) begin
         rec.op     = draw_sprite ? 3'd0 : clear_screen ? 3'd1 : scroll_left ? 3'd2 :
                      scroll_right ? 3'd3 : 3'd4;
         rec.sprite = sprite;
         rec.row    = draw_row;
         rec.col    = draw_col;
         rec.amt    = scroll_down_amount;
         st_q.push_back(rec);
         st_cyc_q.push_back(cyc);
      end
      if (done === 1'b1) begin
         dn_q.push_back({done_collision, done_error});
         dn_cyc_q.push_back(cyc);
      end else if (done_collision === 1'b1 || done_error === 1'b1) begin
         stray_cnt++;
      end
   end

   // Video controller model: reacts to each strobe with a busy pulse or stays silent
   initial begin
      int   d, len;
      logic nv, c;
      ctl_busy   = 1'b0;
      ctl_col    = 1'b0;
      ctl_active = 1'b0;
      forever begin
         @(negedge clk);
         if (ctl_on && (draw_sprite | clear_screen | scroll_left | scroll_right | scroll_down)) begin
            ctl_active = 1'b1;
            if (ctl_rand) begin
               nv  = ($urandom_range(0, 5) == 0);
               d   = $urandom_range(0, 4);
               len = $urandom_range(1, 5);
               c   = 1'($urandom_range(0, 1));
            end else begin
               nv  = ctl_never;
               d   = ctl_delay;
               len = ctl_len;
               c   = ctl_c;
            end
            ctl_q.push_back({nv, c});
            if (!nv) begin
               @(posedge clk); #1;
               repeat (d) begin @(posedge clk); #1; end
               ctl_busy = 1'b1;
               repeat (len) begin @(posedge clk); #1; ctl_col = 1'($urandom); end
               ctl_busy = 1'b0;
               ctl_col  = c;
            end
            ctl_active = 1'b0;
         end
      end
   end

   task automatic push_cmd(input logic [2:0] op, input logic [15:0] spr, input logic [5:0] row,
                           input logic [6:0] col, input logic [3:0] amt, output logic ok,
                           output int acc_cyc);
      int w;
      cif.cmd_valid  = 1'b1;
      cif.cmd_op     = op;
      cif.cmd_sprite = spr;
      cif.cmd_row    = row;
      cif.cmd_col    = col;
      cif.cmd_amount = amt;
      w = 0;
      while (cif.cmd_ready !== 1'b1 && w < 200) begin @(posedge clk); #1; w++; end
      ok = (cif.cmd_ready === 1'b1);
      @(posedge clk); #1;
      acc_cyc = cyc;
      cif.cmd_valid = 1'b0;
   endtask

   task automatic wait_dones(input int n, input int budget, output logic ok);
      int w;
      w = 0;
      while (dn_q.size() < n && w < budget) begin @(posedge clk); #1; w++; end
      ok = (dn_q.size() >= n);
   endtask

   task automatic wait_ctl_idle();
      int w;
      w = 0;
      while (ctl_active && w < 200) begin @(posedge clk); #1; w++; end
   endtask

   task automatic set_ctl(input logic nv, input int d, input int len, input logic c);
      ctl_rand  = 1'b0;
      ctl_never = nv;
      ctl_delay = d;
      ctl_len   = len;
      ctl_c     = c;
      ctl_on    = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      cif.cmd_valid = 1'b1;
      cif.cmd_op = 3'd0;
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if ({draw_sprite, clear_screen, scroll_left, scroll_right, scroll_down} !== 5'b0) begin
         miscompares++;
         $display("FAIL reset_strobes: got %b want 00000",
                  {draw_sprite, clear_screen, scroll_left, scroll_right, scroll_down});
      end
      vectors++;
      if ({sprite, draw_row, draw_col, scroll_down_amount} !== 33'd0) begin
         miscompares++;
         $display("FAIL reset_operands: got %h want 0",
                  {sprite, draw_row, draw_col, scroll_down_amount});
      end
      vectors++;
      if ({done, done_collision, done_error} !== 3'b000) begin
         miscompares++;
         $display("FAIL reset_done: got %b want 000", {done, done_collision, done_error});
      end
      vectors++;
      if ({cif.cmd_ready, idle, fifo_count} !== {1'b1, 1'b1, 5'd0}) begin
         miscompares++;
         $display("FAIL reset_queue: got ready=%b idle=%b count=%0d want 1 1 0",
                  cif.cmd_ready, idle, fifo_count);
      end
      rst = 1'b1;
      cif.cmd_valid = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      vectors++;
      if (fifo_count !== 5'd0 || idle !== 1'b1 || st_q.size() != 0) begin
         miscompares++;
         $display("FAIL reset_no_enqueue: got count=%0d idle=%b strobes=%0d want 0 1 0",
                  fifo_count, idle, st_q.size());
      end
   endtask

   task automatic test_draw_collision();
      logic ok;
      int   ac, sb, db;
      wait_ctl_idle();
      set_ctl(1'b0, 0, 20, 1'b1);
      sb = st_q.size();
      db = dn_q.size();
      push_cmd(3'd0, 16'hF0F0, 6'd5, 7'd10, 4'd0, ok, ac);
      wait_dones(db + 1, 100, ok);
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL draw_done_timeout: got %0d dones want 1", dn_q.size() - db);
      end else begin
         vectors++;
         if (st_q.size() - sb != 1 || st_q[sb].op !== 3'd0) begin
            miscompares++;
            $display("FAIL draw_strobe: got %0d strobes want 1 draw", st_q.size() - sb);
         end else begin
            vectors++;
            if ({st_q[sb].sprite, st_q[sb].row, st_q[sb].col} !== {16'hF0F0, 6'd5, 7'd10}) begin
               miscompares++;
               $display("FAIL draw_operands: got %h/%0d/%0d want F0F0/5/10",
                        st_q[sb].sprite, st_q[sb].row, st_q[sb].col);
            end
         end
         vectors++;
         if (dn_q[db] !== 2'b10) begin
            miscompares++;
            $display("FAIL draw_status: got coll,err=%b want 10", dn_q[db]);
         end
      end
   endtask

   task automatic test_fifo_full();
      logic ok;
      logic exp_rdy;
      int   sb, db;
      wait_ctl_idle();
      ctl_on   = 1'b0;
      man_busy = 1'b1;
      sb = st_q.size();
      db = dn_q.size();
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         cif.cmd_valid  = 1'b1;
         cif.cmd_op     = 3'(i);
         cif.cmd_sprite = 16'($urandom);
         cif.cmd_row    = 6'(i);
         cif.cmd_col    = 7'(i);
         cif.cmd_amount = 4'(i);
         exp_rdy = (i < DEPTH);
         vectors++;
         if (cif.cmd_ready !== exp_rdy) begin
            miscompares++;
            $display("FAIL full_ready_%0d: got %b want %b", i, cif.cmd_ready, exp_rdy);
         end
         @(posedge clk); #1;
      end
      cif.cmd_valid = 1'b0;
      repeat (5) begin @(posedge clk); #1; end
      vectors++;
      if (fifo_count !== 5'(DEPTH) || cif.cmd_ready !== 1'b0 || st_q.size() != sb) begin
         miscompares++;
         $display("FAIL full_hold: got count=%0d ready=%b strobes=%0d want %0d 0 0",
                  fifo_count, cif.cmd_ready, st_q.size() - sb, DEPTH);
      end
      set_ctl(1'b0, 0, 1, 1'b0);
      man_busy = 1'b0;
      wait_dones(db + DEPTH, 200, ok);
      repeat (10) begin @(posedge clk); #1; end
      vectors++;
      if (dn_q.size() - db != DEPTH || st_q.size() - sb != DEPTH) begin
         miscompares++;
         $display("FAIL full_drain: got dones=%0d strobes=%0d want %0d", dn_q.size() - db,
                  st_q.size() - sb, DEPTH);
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            vectors++;
            if (st_q[sb + i].op !== 3'(i)) begin
               miscompares++;
               $display("FAIL full_order_%0d: got op %0d want %0d", i, st_q[sb + i].op, i);
            end
         end
      end
      vectors++;
      if (fifo_count !== 5'd0 || idle !== 1'b1) begin
         miscompares++;
         $display("FAIL full_empty: got count=%0d idle=%b want 0 1", fifo_count, idle);
      end
   endtask

   task automatic test_sequence();
      logic ok;
      int   ac, sb, db;
      wait_ctl_idle();
      set_ctl(1'b0, 1, 2, 1'b1);
      sb = st_q.size();
      db = dn_q.size();
      push_cmd(3'd1, 16'h0, 6'd0, 7'd0, 4'd9, ok, ac);
      push_cmd(3'd2, 16'h0, 6'd0, 7'd0, 4'd7, ok, ac);
      push_cmd(3'd4, 16'h0, 6'd0, 7'd0, 4'd3, ok, ac);
      wait_dones(db + 3, 200, ok);
      repeat (5) begin @(posedge clk); #1; end
      vectors++;
      if (st_q.size() - sb != 3 || dn_q.size() - db != 3) begin
         miscompares++;
         $display("FAIL seq_counts: got strobes=%0d dones=%0d want 3 3", st_q.size() - sb,
                  dn_q.size() - db);
      end else begin
         vectors++;
         if ({st_q[sb].op, st_q[sb + 1].op, st_q[sb + 2].op} !== {3'd1, 3'd2, 3'd4}) begin
            miscompares++;
            $display("FAIL seq_order: got %0d,%0d,%0d want 1,2,4", st_q[sb].op,
                     st_q[sb + 1].op, st_q[sb + 2].op);
         end
         vectors++;
         if (st_q[sb + 2].amt !== 4'd3) begin
            miscompares++;
            $display("FAIL seq_amount: got %0d want 3", st_q[sb + 2].amt);
         end
         for (int i = 0; i < 3; i++) begin
            vectors++;
            if (dn_q[db + i] !== 2'b00) begin
               miscompares++;
               $display("FAIL seq_status_%0d: got coll,err=%b want 00", i, dn_q[db + i]);
            end
         end
         vectors++;
         if (st_cyc_q[sb + 1] - st_cyc_q[sb] < 4 || st_cyc_q[sb + 2] - st_cyc_q[sb + 1] < 4) begin
            miscompares++;
            $display("FAIL seq_spacing: got %0d,%0d cycles want >=4",
                     st_cyc_q[sb + 1] - st_cyc_q[sb], st_cyc_q[sb + 2] - st_cyc_q[sb + 1]);
         end
      end
   endtask

   task automatic test_illegal();
      logic ok;
      int   ac, sb, db;
      wait_ctl_idle();
      set_ctl(1'b0, 0, 1, 1'b0);
      sb = st_q.size();
      db = dn_q.size();
      push_cmd(3'd6, 16'hAAAA, 6'd1, 7'd1, 4'd1, ok, ac);
      push_cmd(3'd0, 16'h5555, 6'd2, 7'd3, 4'd0, ok, ac);
      wait_dones(db + 2, 100, ok);
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL illegal_timeout: got %0d dones want 2", dn_q.size() - db);
      end else begin
         vectors++;
         if (dn_q[db] !== 2'b01) begin
            miscompares++;
            $display("FAIL illegal_status: got coll,err=%b want 01", dn_q[db]);
         end
         vectors++;
         if (st_q.size() - sb != 1 || st_q[sb].op !== 3'd0 || st_q[sb].sprite !== 16'h5555) begin
            miscompares++;
            $display("FAIL illegal_follow: got %0d strobes want 1 draw of 5555", st_q.size() - sb);
         end
         vectors++;
         if (dn_q[db + 1] !== 2'b00) begin
            miscompares++;
            $display("FAIL illegal_follow_status: got coll,err=%b want 00", dn_q[db + 1]);
         end
      end
   endtask

   task automatic test_timeout();
      logic ok;
      int   ac, sb, db;
      wait_ctl_idle();
      set_ctl(1'b1, 0, 0, 1'b0);
      sb = st_q.size();
      db = dn_q.size();
      push_cmd(3'd0, 16'h1111, 6'd3, 7'd4, 4'd0, ok, ac);
      wait_dones(db + 1, 60, ok);
      vectors++;
      if (!ok || st_q.size() - sb != 1) begin
         miscompares++;
         $display("FAIL timeout_done: got dones=%0d strobes=%0d want 1 1", dn_q.size() - db,
                  st_q.size() - sb);
      end else begin
         vectors++;
         if (dn_q[db] !== 2'b01) begin
            miscompares++;
            $display("FAIL timeout_status: got coll,err=%b want 01", dn_q[db]);
         end
         vectors++;
         if (dn_cyc_q[db] - st_cyc_q[sb] != TMO + 1) begin
            miscompares++;
            $display("FAIL timeout_latency: got %0d cycles want %0d",
                     dn_cyc_q[db] - st_cyc_q[sb], TMO + 1);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic ok;
      int   ac, sb, db, w;
      wait_ctl_idle();
      set_ctl(1'b0, 0, 30, 1'b0);
      sb = st_q.size();
      db = dn_q.size();
      push_cmd(3'd0, 16'h1234, 6'd1, 7'd2, 4'd0, ok, ac);
      w = 0;
      while (st_q.size() == sb && w < 20) begin @(posedge clk); #1; w++; end
      repeat (3) begin @(posedge clk); #1; end
      push_cmd(3'd1, 16'h0, 6'd0, 7'd0, 4'd0, ok, ac);
      push_cmd(3'd2, 16'h0, 6'd0, 7'd0, 4'd0, ok, ac);
      vectors++;
      if (fifo_count !== 5'd2) begin
         miscompares++;
         $display("FAIL rstmid_queued: got %0d want 2", fifo_count);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      vectors++;
      if (idle !== 1'b1 || fifo_count !== 5'd0 || cif.cmd_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL rstmid_flush: got idle=%b count=%0d ready=%b want 1 0 1", idle,
                  fifo_count, cif.cmd_ready);
      end
      repeat (40) begin @(posedge clk); #1; end
      vectors++;
      if (dn_q.size() != db || st_q.size() != sb + 1) begin
         miscompares++;
         $display("FAIL rstmid_quiet: got dones=%0d strobes=%0d want 0 1", dn_q.size() - db,
                  st_q.size() - sb);
      end
   endtask

   task automatic test_random();
      cmd_t exp_q[$];
      cmd_t c;
      logic ok, nv, cl, exp_err, exp_coll;
      int   ac, sb, db, cb, si, ci, n_legal;
      wait_ctl_idle();
      ctl_rand = 1'b1;
      ctl_on   = 1'b1;
      sb = st_q.size();
      db = dn_q.size();
      cb = ctl_q.size();
      for (int i = 0; i < 40; i++) begin
         c.op     = 3'($urandom_range(0, 7));
         c.sprite = 16'($urandom);
         c.row    = 6'($urandom);
         c.col    = 7'($urandom);
         c.amt    = 4'($urandom);
         push_cmd(c.op, c.sprite, c.row, c.col, c.amt, ok, ac);
         vectors++;
         if (!ok) begin
            miscompares++;
            $display("FAIL rand_push_%0d: got ready=0 want accept", i);
         end else begin
            exp_q.push_back(c);
         end
         repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      end
      wait_dones(db + exp_q.size(), 4000, ok);
      repeat (10) begin @(posedge clk); #1; end
      n_legal = 0;
      foreach (exp_q[k]) if (exp_q[k].op <= 3'd4) n_legal++;
      vectors++;
      if (dn_q.size() - db != exp_q.size() || st_q.size() - sb != n_legal) begin
         miscompares++;
         $display("FAIL rand_counts: got dones=%0d strobes=%0d want %0d %0d", dn_q.size() - db,
                  st_q.size() - sb, exp_q.size(), n_legal);
      end else begin
         si = sb;
         ci = cb;
         foreach (exp_q[k]) begin
            exp_err  = 1'b1;
            exp_coll = 1'b0;
            if (exp_q[k].op <= 3'd4) begin
               vectors++;
               if (st_q[si].op !== exp_q[k].op) begin
                  miscompares++;
                  $display("FAIL rand_op_%0d: got %0d want %0d", k, st_q[si].op, exp_q[k].op);
               end
               if (exp_q[k].op == 3'd0) begin
                  vectors++;
                  if ({st_q[si].sprite, st_q[si].row, st_q[si].col} !==
                      {exp_q[k].sprite, exp_q[k].row, exp_q[k].col}) begin
                     miscompares++;
                     $display("FAIL rand_draw_%0d: got %h/%0d/%0d want %h/%0d/%0d", k,
                              st_q[si].sprite, st_q[si].row, st_q[si].col, exp_q[k].sprite,
                              exp_q[k].row, exp_q[k].col);
                  end
               end
               if (exp_q[k].op == 3'd4) begin
                  vectors++;
                  if (st_q[si].amt !== exp_q[k].amt) begin
                     miscompares++;
                     $display("FAIL rand_amt_%0d: got %0d want %0d", k, st_q[si].amt,
                              exp_q[k].amt);
                  end
               end
               si++;
               {nv, cl} = (ci < ctl_q.size()) ? ctl_q[ci] : 2'b10;
               ci++;
               exp_err  = nv;
               exp_coll = (exp_q[k].op == 3'd0) && !nv && cl;
            end
            vectors++;
            if (dn_q[db + k] !== {exp_coll, exp_err}) begin
               miscompares++;
               $display("FAIL rand_status_%0d: got coll,err=%b want %b", k, dn_q[db + k],
                        {exp_coll, exp_err});
            end
         end
      end
      vectors++;
      if (multi_cnt != 0 || stray_cnt != 0 || idle !== 1'b1 || fifo_count !== 5'd0) begin
         miscompares++;
         $display("FAIL rand_final: got multi=%0d stray=%0d idle=%b count=%0d want 0 0 1 0",
                  multi_cnt, stray_cnt, idle, fifo_count);
      end
   endtask

   initial begin
      rst            = 1'b0;
      man_busy       = 1'b0;
      man_col        = 1'b0;
      ctl_on         = 1'b0;
      ctl_rand       = 1'b0;
      ctl_never      = 1'b0;
      ctl_c          = 1'b0;
      ctl_delay      = 0;
      ctl_len        = 1;
      cif.cmd_valid  = 1'b0;
      cif.cmd_op     = 3'd0;
      cif.cmd_sprite = 16'd0;
      cif.cmd_row    = 6'd0;
      cif.cmd_col    = 7'd0;
      cif.cmd_amount = 4'd0;
      test_reset();
      test_draw_collision();
      test_fifo_full();
      test_sequence();
      test_illegal();
      test_timeout();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
